// File: rtl/block_pe_param.sv
// Parameterised CGRA processing element: operand crossbar, registered ALU with
// accumulate, programmable delay line, per-port output select, serial config chain.

module block_pe_param_oport #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_alu_q,
  input  logic             i_alu_v,
  input  logic [WIDTH-1:0] i_dl_q,
  input  logic             i_dl_v,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);
  assign o_data  = i_sel ? i_dl_q : i_alu_q;
  assign o_valid = i_sel ? i_dl_v : i_alu_v;
endmodule

module block_pe_param #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   config_en,
  input  logic                   config_in,
  output logic                   config_out,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid
);
  localparam int S     = N_IN + 2;
  localparam int SELW  = $clog2(S);
  localparam int DLW   = $clog2(DEPTH);
  localparam int CFG_W = 4 + 3*SELW + DLW + N_OUT;
  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SA_LO = 4;
  localparam int SB_LO = SA_LO + SELW;
  localparam int DS_LO = SB_LO + SELW;
  localparam int DL_LO = DS_LO + SELW;
  localparam int OS_LO = DL_LO + DLW;

  logic [CFG_W-1:0]            r_cfg;
  logic [WIDTH-1:0]            r_alu_q;
  logic                        r_alu_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_dl_d;
  logic [DEPTH-1:0]            r_vld_pipe;

  logic [3:0]       w_op;
  logic [SELW-1:0]  w_sa, w_sb, w_ds;
  logic [DLW-1:0]   w_dly;
  logic [N_OUT-1:0] w_osel;

  assign w_op   = r_cfg[3:0];
  assign w_sa   = r_cfg[SA_LO +: SELW];
  assign w_sb   = r_cfg[SB_LO +: SELW];
  assign w_ds   = r_cfg[DS_LO +: SELW];
  assign w_dly  = r_cfg[DL_LO +: DLW];
  assign w_osel = r_cfg[OS_LO +: N_OUT];
  assign config_out = r_cfg[0];

  logic [WIDTH-1:0] w_dl_q;
  logic             w_dl_v;
  assign w_dl_q = r_dl_d[w_dly];
  assign w_dl_v = r_vld_pipe[w_dly];

  // Source table: inputs, then ALU register, then delay-line tap.
  logic [S-1:0][WIDTH-1:0] w_src_d;
  logic [S-1:0]            w_src_v;
  always_comb begin
    w_src_d = '0;
    w_src_v = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_src_d[k] = in_data[k*WIDTH +: WIDTH];
      w_src_v[k] = in_valid[k];
    end
    w_src_d[N_IN]   = r_alu_q;
    w_src_v[N_IN]   = r_alu_v;
    w_src_d[N_IN+1] = w_dl_q;
    w_src_v[N_IN+1] = w_dl_v;
  end

  // Unused select codes (>= S) read as invalid zero.
  function automatic logic [WIDTH:0] pick(input logic [SELW-1:0]         sel,
                                          input logic [S-1:0][WIDTH-1:0] d,
                                          input logic [S-1:0]            v);
    logic [WIDTH:0] r;
    r = '0;
    for (int k = 0; k < S; k++)
      if (sel == SELW'(k)) r = {v[k], d[k]};
    return r;
  endfunction

  logic [WIDTH-1:0] w_a, w_b, w_d_d;
  logic             w_va, w_vb, w_d_v;
  assign {w_va, w_a}   = pick(w_sa, w_src_d, w_src_v);
  assign {w_vb, w_b}   = pick(w_sb, w_src_d, w_src_v);
  assign {w_d_v, w_d_d} = pick(w_ds, w_src_d, w_src_v);

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_alu_en;
  assign w_sh = w_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    case (w_op)
      4'd0:  w_res = w_a + w_b;
      4'd1:  w_res = w_a - w_b;
      4'd2:  w_res = w_a * w_b;
      4'd3:  w_res = w_a & w_b;
      4'd4:  w_res = w_a | w_b;
      4'd5:  w_res = w_a ^ w_b;
      4'd6:  w_res = w_a << w_sh;
      4'd7:  w_res = w_a >> w_sh;
      4'd8:  w_res = $signed(w_a) >>> w_sh;
      4'd9:  w_res = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      4'd10: w_res = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
      4'd11: w_res = w_a;
      4'd12: w_res = WIDTH'(w_a == w_b);
      4'd13: w_res = WIDTH'($signed(w_a) < $signed(w_b));
      4'd14: w_res = r_alu_q + w_a;
      default: w_res = '0;
    endcase
  end

  // Unary ops (pass, accumulate) must not stall on an unused B operand.
  assign w_alu_en = (w_op == 4'd11 || w_op == 4'd14) ? w_va : (w_va & w_vb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg      <= '0;
      r_alu_q    <= '0;
      r_alu_v    <= 1'b0;
      r_dl_d     <= '0;
      r_vld_pipe <= '0;
    end else if (config_en) begin
      r_cfg      <= {config_in, r_cfg[CFG_W-1:1]};
      r_alu_q    <= '0;
      r_alu_v    <= 1'b0;
      r_dl_d     <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_alu_en) r_alu_q <= w_res;
      r_alu_v    <= w_alu_en;
      r_dl_d     <= {r_dl_d[DEPTH-2:0], w_d_d};
      r_vld_pipe <= {r_vld_pipe[DEPTH-2:0], w_d_v};
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_oport
    block_pe_param_oport #(.WIDTH(WIDTH)) u_oport (
      .i_sel   (w_osel[k]),
      .i_alu_q (r_alu_q),
      .i_alu_v (r_alu_v),
      .i_dl_q  (w_dl_q),
      .i_dl_v  (w_dl_v),
      .o_data  (out_data[k*WIDTH +: WIDTH]),
      .o_valid (out_valid[k])
    );
  end

endmodule
